ram_fifo_ctrl: RTL

// - FIFO controller sitting directly upstream of the team's 128x8 single-port synchronous RAM.
// - Converts a valid/ready byte stream into RAM write/read cycles (ram_we/ram_addr/ram_din),

---
 rtl/ram_fifo_ctrl_pkg.sv | 13 +
 rtl/ram_fifo_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared FSM encoding and default widths for the RAM-backed byte FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    FETCH     = 2'd1,
    OUT_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO on an external single-port sync RAM; first byte out 3 cycles after its write.
// Reads take the RAM port over writes; in_ready drops when full or a read is issued.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   fill,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     cnt;
  logic                rd_issue;
  logic                wr_fire;

  // A read is only launched when the output register will be free by the time data returns.
  assign rd_issue = ((state == OUT_EMPTY) || ((state == OUT_FULL) && out_ready)) &&
                    (cnt != '0);
  assign in_ready = (cnt < CNT_FULL) && !rd_issue && !rst;
  assign wr_fire  = in_valid && in_ready;

  assign ram_we    = wr_fire;
  assign ram_addr  = wr_fire ? wr_ptr : rd_ptr;
  assign ram_din   = in_data;
  assign out_valid = (state == OUT_FULL);
  assign fill      = cnt + {{ADDR_W{1'b0}}, out_valid};

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (rd_issue) state_nxt = FETCH;
      FETCH:     state_nxt = OUT_FULL;
      OUT_FULL: begin
        if (out_ready) state_nxt = rd_issue ? FETCH : OUT_EMPTY;
      end
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OUT_EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        cnt    <= cnt + CNT_ONE;
      end else if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        cnt    <= cnt - CNT_ONE;
      end
      if (state == FETCH) out_data <= ram_dout;
    end
  end

endmodule
